// File: rtl/mem_arbiter_if.sv
// Single-outstanding request/response bus shared by the instruction, data and memory sides.
// The requester drives the master modport; the responder drives the slave modport.
interface mem_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client arbiter (instruction/data) onto one memory port, one transaction in flight.
// Data has priority; instruction is forced after STARVE_MAX data grants while it waits.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  mem_arbiter_if.slave  inst_if,
  mem_arbiter_if.slave  data_if,
  mem_arbiter_if.master mem_if,
  input  logic          inst_cancel_i
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] StarveMaxC = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q, state_d;
  logic            owner_inst_q, owner_inst_d;
  logic            wr_q, wr_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            cancel_q, cancel_d;

  logic grant_inst, grant_data, inst_ok;
  logic done, inst_done, data_done;

  // A cancel seen in the idle cycle suppresses the instruction grant for that cycle.
  assign inst_ok = inst_if.req && !inst_cancel_i;

  always_comb begin
    state_d      = state_q;
    owner_inst_d = owner_inst_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cancel_d     = cancel_q;
    grant_inst   = 1'b0;
    grant_data   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cancel_d = 1'b0;
        if (resetn_i) begin
          if (data_if.req && !(inst_ok && starve_q == StarveMaxC)) begin
            grant_data = 1'b1;
          end else if (inst_ok) begin
            grant_inst = 1'b1;
          end
        end
        if (grant_inst) begin
          owner_inst_d = 1'b1;
          wr_d         = inst_if.wr;
          size_d       = inst_if.size;
          addr_d       = inst_if.addr;
          wdata_d      = inst_if.wdata;
          state_d      = StReq;
        end else if (grant_data) begin
          owner_inst_d = 1'b0;
          wr_d         = data_if.wr;
          size_d       = data_if.size;
          addr_d       = data_if.addr;
          wdata_d      = data_if.wdata;
          state_d      = StReq;
        end
      end
      StReq: begin
        if (owner_inst_q && inst_cancel_i) cancel_d = 1'b1;
        if (mem_if.addr_ok) state_d = StWait;
      end
      StWait: begin
        if (owner_inst_q && inst_cancel_i) cancel_d = 1'b1;
        if (mem_if.data_ok) begin
          state_d  = StIdle;
          cancel_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!inst_if.req || grant_inst) begin
      starve_d = '0;
    end else if (grant_data && starve_q != StarveMaxC) begin
      starve_d = starve_q + CntW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      owner_inst_q <= 1'b1;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      starve_q     <= '0;
      cancel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_inst_q <= owner_inst_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      cancel_q     <= cancel_d;
    end
  end

  assign done      = (state_q == StWait) && mem_if.data_ok;
  assign inst_done = done && owner_inst_q && !cancel_q && !inst_cancel_i;
  assign data_done = done && !owner_inst_q;

  assign inst_if.addr_ok = grant_inst;
  assign data_if.addr_ok = grant_data;
  assign inst_if.data_ok = inst_done;
  assign data_if.data_ok = data_done;
  assign inst_if.rdata   = inst_done ? mem_if.rdata : 32'd0;
  assign data_if.rdata   = data_done ? mem_if.rdata : 32'd0;

  assign mem_if.req   = (state_q == StReq);
  assign mem_if.wr    = wr_q;
  assign mem_if.size  = size_q;
  assign mem_if.addr  = addr_q;
  assign mem_if.wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a delay-configurable memory responder plus per-side response
// scoreboards filled on each grant and drained on each data_ok.
module tb_mem_arbiter;

  logic clk;
  logic resetn;
  logic inst_cancel;

  mem_arbiter_if inst_if ();
  mem_arbiter_if data_if ();
  mem_arbiter_if mem_if ();

  mem_arbiter #(
    .STARVE_MAX(3)
  ) dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .inst_if      (inst_if),
    .data_if      (data_if),
    .mem_if       (mem_if),
    .inst_cancel_i(inst_cancel)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          grant_cnt = 0;
  int          base;
  int          addr_delay = 0;
  int          data_delay = 0;
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic        order_q[$];
  logic        exp_side;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return (a ^ 32'hA5A5_0F0F) + 32'd7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Memory responder: addr_ok after addr_delay REQ cycles, data_ok after data_delay more.
  initial begin : responder
    int          phase;
    int          cnt;
    logic [31:0] cur_addr;
    phase = 0;
    cnt = 0;
    cur_addr = 32'd0;
    mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      mem_if.addr_ok = 1'b0;
      mem_if.data_ok = 1'b0;
      mem_if.rdata   = 32'd0;
      if (phase == 0 && mem_if.req) begin
        if (cnt >= addr_delay) begin
          mem_if.addr_ok = 1'b1;
          cur_addr = mem_if.addr;
          phase = 1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (phase == 1) begin
        if (cnt >= data_delay) begin
          mem_if.data_ok = 1'b1;
          mem_if.rdata   = mem_model(cur_addr);
          phase = 0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (inst_if.addr_ok || data_if.addr_ok) begin
      check_eq("addr_ok_exclusive", 32'(inst_if.addr_ok & data_if.addr_ok), 32'd0);
      grant_cnt++;
      if (inst_if.addr_ok) inst_q.push_back(mem_model(inst_if.addr));
      if (data_if.addr_ok) data_q.push_back(mem_model(data_if.addr));
      if (order_q.size() > 0) begin
        exp_side = order_q.pop_front();
        check_eq("grant_order_inst", 32'(inst_if.addr_ok), 32'(exp_side));
      end
    end
    if (inst_if.data_ok) begin
      if (inst_q.size() == 0) check_eq("inst_data_ok_unexpected", 32'd1, 32'd0);
      else check_eq("inst_rdata", inst_if.rdata, inst_q.pop_front());
    end
    if (data_if.data_ok) begin
      if (data_q.size() == 0) check_eq("data_data_ok_unexpected", 32'd1, 32'd0);
      else check_eq("data_rdata", data_if.rdata, data_q.pop_front());
    end
    check_eq("inst_rdata_quiet", inst_if.data_ok ? 32'd0 : inst_if.rdata, 32'd0);
    check_eq("data_rdata_quiet", data_if.data_ok ? 32'd0 : data_if.rdata, 32'd0);
  end

  initial begin
    resetn      = 1'b0;
    inst_cancel = 1'b0;
    inst_if.req = 1'b1;  inst_if.wr = 1'b0;  inst_if.size = 2'd2;
    inst_if.addr = 32'hBFC0_0000;  inst_if.wdata = 32'd0;
    data_if.req = 1'b1;  data_if.wr = 1'b0;  data_if.size = 2'd2;
    data_if.addr = 32'h8000_0000;  data_if.wdata = 32'd0;
    #2;
    check_eq("rst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    check_eq("rst_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    check_eq("rst_m_req", 32'(mem_if.req), 32'd0);
    check_eq("rst_m_addr", mem_if.addr, 32'd0);
    tick();
    inst_if.req = 1'b0;
    data_if.req = 1'b0;
    tick();
    resetn = 1'b1;

    // Minimum-latency instruction fetch.
    tick();
    inst_if.req = 1'b1;
    inst_if.addr = 32'hBFC0_0000;
    #1;
    check_eq("fetch_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    check_eq("fetch_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    inst_if.req = 1'b0;
    #1;
    check_eq("fetch_m_req", 32'(mem_if.req), 32'd1);
    check_eq("fetch_m_addr", mem_if.addr, 32'hBFC0_0000);
    tick();
    #1;
    check_eq("fetch_inst_data_ok", 32'(inst_if.data_ok), 32'd1);
    check_eq("fetch_inst_rdata", inst_if.rdata, 32'h2408_0001);
    check_eq("fetch_wait_m_req", 32'(mem_if.req), 32'd0);
    tick();
    #1;
    check_eq("fetch_idle_m_req", 32'(mem_if.req), 32'd0);
    check_eq("fetch_idle_data_ok", 32'(inst_if.data_ok), 32'd0);

    // Data write held off by a slow addr_ok.
    addr_delay = 5;
    tick();
    data_if.req = 1'b1;  data_if.wr = 1'b1;  data_if.size = 2'd2;
    data_if.addr = 32'h8000_1000;  data_if.wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      data_if.req = 1'b0;
      inst_if.req = 1'b1;
      inst_if.addr = 32'h0000_4000;
      #1;
      check_eq("hold_m_req", 32'(mem_if.req), 32'd1);
      check_eq("hold_m_addr", mem_if.addr, 32'h8000_1000);
      check_eq("hold_m_wdata", mem_if.wdata, 32'hDEAD_BEEF);
      check_eq("hold_m_wr_size", 32'({mem_if.wr, mem_if.size}), 32'h6);
      check_eq("hold_no_grant", 32'(inst_if.addr_ok | data_if.addr_ok), 32'd0);
    end
    tick();
    addr_delay = 0;
    inst_if.req = 1'b0;
    data_if.wr = 1'b0;
    #1;
    check_eq("wr_data_ok", 32'(data_if.data_ok), 32'd1);
    tick();

    // Both sides held: data three times, then instruction, repeating.
    tick();
    order_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    base = grant_cnt;
    inst_if.req = 1'b1;  inst_if.addr = 32'h0000_4000;
    data_if.req = 1'b1;  data_if.addr = 32'h8000_2000;
    for (int i = 0; i < 40 && grant_cnt < base + 8; i++) tick();
    inst_if.req = 1'b0;
    data_if.req = 1'b0;
    check_eq("starve_grant_count", 32'(grant_cnt - base), 32'd8);
    tick(); tick(); tick();
    check_eq("starve_order_drained", 32'(order_q.size()), 32'd0);

    // Cancel an instruction fetch while waiting; data queued behind it.
    data_delay = 2;
    tick();
    inst_if.req = 1'b1;
    inst_if.addr = 32'h0000_5000;
    #1;
    check_eq("cancel_inst_addr_ok", 32'(inst_if.addr_ok), 32'd1);
    tick();
    inst_if.req = 1'b0;
    tick();
    inst_cancel = 1'b1;
    check_eq("cancel_q_depth", 32'(inst_q.size()), 32'd1);
    void'(inst_q.pop_front());
    tick();
    inst_cancel = 1'b0;
    tick();
    data_if.req = 1'b1;
    data_if.addr = 32'h8000_6000;
    #1;
    check_eq("cancel_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    check_eq("cancel_no_grant_on_done", 32'(data_if.addr_ok), 32'd0);
    tick();
    data_delay = 0;
    #1;
    check_eq("cancel_next_data_grant", 32'(data_if.addr_ok), 32'd1);
    tick();
    data_if.req = 1'b0;
    tick();
    data_if.req = 1'b1;
    data_if.addr = 32'h8000_7000;
    #1;
    check_eq("b2b_data_data_ok", 32'(data_if.data_ok), 32'd1);
    check_eq("b2b_data_addr_ok_late", 32'(data_if.addr_ok), 32'd0);
    tick();
    #1;
    check_eq("b2b_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    tick();
    data_if.req = 1'b0;
    tick(); tick();

    // Reset in the middle of a data transaction; late response must be ignored.
    data_delay = 3;
    tick();
    data_if.req = 1'b1;  data_if.addr = 32'h8000_3000;
    inst_if.req = 1'b1;  inst_if.addr = 32'h0000_4000;
    #1;
    check_eq("rstw_data_addr_ok", 32'(data_if.addr_ok), 32'd1);
    tick();
    data_if.req = 1'b0;
    tick();
    resetn = 1'b0;
    void'(data_q.pop_front());
    #1;
    check_eq("rstw_m_req", 32'(mem_if.req), 32'd0);
    check_eq("rstw_m_addr", mem_if.addr, 32'd0);
    check_eq("rstw_m_wdata", mem_if.wdata, 32'd0);
    check_eq("rstw_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    check_eq("rstw_data_data_ok", 32'(data_if.data_ok), 32'd0);
    tick();
    check_eq("rstw_starve_cnt", 32'(dut.starve_q), 32'd0);
    inst_if.req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    data_delay = 0;
    #1;
    check_eq("late_rsp_data_data_ok", 32'(data_if.data_ok), 32'd0);
    check_eq("late_rsp_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
    tick();
    data_if.req = 1'b1;
    data_if.addr = 32'h8000_4000;
    #1;
    check_eq("post_rst_grant", 32'(data_if.addr_ok), 32'd1);
    tick();
    data_if.req = 1'b0;
    #1;
    check_eq("post_rst_m_req", 32'(mem_if.req), 32'd1);
    check_eq("post_rst_m_addr", mem_if.addr, 32'h8000_4000);
    tick();
    #1;
    check_eq("post_rst_data_ok", 32'(data_if.data_ok), 32'd1);
    tick(); tick();

    check_eq("inst_q_drained", 32'(inst_q.size()), 32'd0);
    check_eq("data_q_drained", 32'(data_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive data grants allowed while inst_req is pending before inst is forced.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req / inst_wr  in  1 / 1  instruction-side request and write flag.
REQ-005 inst_size / inst_addr / inst_wdata  in  2 / 32 / 32  instruction-side size, address and write data.
REQ-006 inst_addr_ok / inst_data_ok  out  1 / 1  instruction-side accept and completion pulses.
REQ-007 inst_rdata  out  32  instruction-side read data, valid with inst_data_ok.
REQ-008 inst_cancel  in  1  discards any outstanding instruction transaction's response (pipeline refresh).
REQ-009 data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same widths and meanings as the inst_* ports, for the data side.
REQ-010 m_req, m_wr, m_size, m_addr, m_wdata  out  1/1/2/32/32  shared downstream request port.
REQ-011 m_addr_ok / m_data_ok / m_rdata  in  1 / 1 / 32  downstream accept, completion and read data.

Function
REQ-012 FSM states: IDLE, REQ, WAIT; at most one transaction outstanding downstream.
REQ-013 IDLE with only data_req set: grant data; with only inst_req set: grant inst; with neither set: stay in IDLE.
REQ-014 IDLE with both set: grant data unless starve_cnt == STARVE_MAX, in which case grant inst.
REQ-015 Grant cycle: pulse the granted side's *_addr_ok for 1 cycle, latch wr/size/addr/wdata and owner, go to REQ.
REQ-016 Never assert addr_ok to the non-granted side, and never assert addr_ok outside IDLE.
REQ-017 REQ: m_req=1 and m_wr/m_size/m_addr/m_wdata driven from the latched registers; on m_addr_ok go to WAIT, otherwise hold every output unchanged.
REQ-018 WAIT: m_req=0; on m_data_ok assert the owner's *_data_ok combinationally in the same cycle, drive *_rdata = m_rdata, and go to IDLE.
REQ-019 No grant in the cycle m_data_ok is consumed; the earliest next grant is the following cycle (IDLE).
REQ-020 Minimum latency: grant at cycle 0, m_req at cycle 1, data_ok at cycle 2 if m_addr_ok arrives at cycle 1 and m_data_ok at cycle 2.
REQ-021 Outputs in IDLE: m_req=0 and no *_data_ok.
REQ-022 Non-owner *_data_ok is 0 at all times; *_rdata is 0 whenever the matching *_data_ok is 0.
REQ-023 starve_cnt (clog2(STARVE_MAX+1) bits) increments on a data grant while inst_req=1.
REQ-024 starve_cnt clears on an inst grant, and on any cycle with inst_req=0.
REQ-025 starve_cnt saturates at STARVE_MAX and never wraps.
REQ-026 inst_cancel=1 while owner=inst in REQ or WAIT sets cancel_pend.
REQ-027 With cancel_pend set, the FSM still completes the downstream handshake.
REQ-028 With cancel_pend set, inst_data_ok is suppressed (0) on completion; cancel_pend clears on return to IDLE.
REQ-029 inst_cancel has no effect when owner=data or in IDLE, except that inst_cancel in IDLE blocks an inst grant that cycle.
REQ-030 The downstream transaction is never aborted mid-flight; m_req is never deasserted in REQ before m_addr_ok.

Reset
REQ-031 resetn=0 asynchronously forces IDLE, starve_cnt=0, cancel_pend=0 and owner=inst, and clears all latched request registers.
REQ-032 resetn=0 forces all outputs to 0 immediately, including mid-transaction.
REQ-033 After resetn rises, the first grant is possible on the first rising edge.
REQ-034 A downstream response arriving after a mid-transaction reset is ignored (FSM is in IDLE).

Verification
REQ-035 inst_req=1 alone, addr 0xBFC00000, m_addr_ok at cycle 1, m_data_ok at cycle 2 with m_rdata 0x24080001 -> inst_addr_ok at cycle 0, inst_data_ok and inst_rdata 0x24080001 at cycle 2.
REQ-036 inst_req and data_req both held, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; inst_addr_ok never coincides with data_addr_ok.
REQ-037 Data write (wr=1, size=2, addr 0x80001000, wdata 0xDEADBEEF) with m_addr_ok withheld 5 cycles -> m_req and all m_* fields stable for 6 cycles; no second grant.
REQ-038 inst_cancel pulse in WAIT with owner=inst -> m_data_ok consumed, inst_data_ok=0, next data_req granted the cycle after.
REQ-039 resetn=0 during WAIT, then m_data_ok -> all outputs 0 at once, no data_ok to either side, starve_cnt=0.
REQ-040 m_data_ok with data_req already pending -> data_data_ok that cycle, data_addr_ok exactly one cycle later.
